// File: rtl/mult_pkg.sv
// Shared state encoding and default operand width for the multiplier arbiter.
// Pure declarations, no logic; no latency or flow-control implications.
package mult_pkg;

  localparam int W_DEF = 3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    ARM     = 3'd2,
    WAIT    = 3'd3,
    DELIVER = 3'd4
  } state_e;

endpackage

// File: rtl/mult_arbiter_rr.sv
// Two-port round-robin grant: the grant is combinational and the last pointer is registered.
// The pointer moves only when en is high; requests are levels, so no backpressure is involved.
module rr_arbiter2 (
  input  logic clk,
  input  logic reset,
  input  logic req0_i,
  input  logic req1_i,
  input  logic en_i,
  output logic gnt_vld_o,
  output logic gnt_id_o
);

  logic last_q, last_d;

  always_comb begin
    gnt_vld_o = req0_i | req1_i;
    // A tie goes to the port that was not served most recently.
    if (req0_i && req1_i) gnt_id_o = ~last_q;
    else                  gnt_id_o = req1_i;
    last_d = (en_i && gnt_vld_o) ? gnt_id_o : last_q;
  end

  always_ff @(posedge clk) begin
    if (reset) last_q <= 1'b1;
    else       last_q <= last_d;
  end

endmodule

// File: rtl/mult_arbiter.sv
// Lets two requesters share one sequential signed multiplier. Grant to done takes 3 cycles plus the multiplier latency.
// Requests are held levels: a loser waits in IDLE, and a multiplier that never finishes is aborted by the watchdog.
module mult_arbiter
  import mult_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int TIMEOUT = 31,
  parameter int TW      = 5
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req0,
  input  logic [W-1:0]   a0,
  input  logic [W-1:0]   b0,
  input  logic           req1,
  input  logic [W-1:0]   a1,
  input  logic [W-1:0]   b1,
  output logic           done0,
  output logic [2*W-1:0] res0,
  output logic           err0,
  output logic           done1,
  output logic [2*W-1:0] res1,
  output logic           err1,
  output logic [W-1:0]   m_multiplicando,
  output logic [W-1:0]   m_multiplicador,
  output logic           m_start,
  input  logic [2*W-1:0] m_resultado,
  input  logic           m_fin,
  output logic           busy
);

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             err_q, err_d;
  logic [TW-1:0]    wd_q, wd_d;
  logic [W-1:0]     mcand_q, mcand_d;
  logic [W-1:0]     mplier_q, mplier_d;
  logic [2*W-1:0]   res0_q, res0_d;
  logic [2*W-1:0]   res1_q, res1_d;
  logic             gnt_vld, gnt_id, arb_en;

  assign arb_en = (state_q == IDLE);

  rr_arbiter2 u_rr (
    .clk       (clk),
    .reset     (reset),
    .req0_i    (req0),
    .req1_i    (req1),
    .en_i      (arb_en),
    .gnt_vld_o (gnt_vld),
    .gnt_id_o  (gnt_id)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    err_d    = err_q;
    wd_d     = wd_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    res0_d   = res0_q;
    res1_d   = res1_q;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          mcand_d  = gnt_id ? a1 : a0;
          mplier_d = gnt_id ? b1 : b0;
          owner_d  = gnt_id;
          err_d    = 1'b0;
          state_d  = LAUNCH;
        end
      end
      LAUNCH: begin
        wd_d    = '0;
        state_d = ARM;
      end
      ARM, WAIT: begin
        // A result that lands on the last allowed cycle still wins over the timeout.
        if (state_q == WAIT && m_fin) begin
          if (owner_q) res1_d = m_resultado;
          else         res0_d = m_resultado;
          state_d = DELIVER;
        end else if (wd_q == TW'(TIMEOUT - 1)) begin
          if (owner_q) res1_d = '0;
          else         res0_d = '0;
          err_d   = 1'b1;
          state_d = DELIVER;
        end else begin
          wd_d = wd_q + TW'(1);
          if (state_q == ARM && !m_fin) state_d = WAIT;
        end
      end
      DELIVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      err_q    <= 1'b0;
      wd_q     <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      res0_q   <= '0;
      res1_q   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      err_q    <= err_d;
      wd_q     <= wd_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      res0_q   <= res0_d;
      res1_q   <= res1_d;
    end
  end

  assign m_multiplicando = mcand_q;
  assign m_multiplicador = mplier_q;
  assign m_start         = (state_q == LAUNCH);
  assign busy            = (state_q != IDLE);
  assign done0           = (state_q == DELIVER) && !owner_q;
  assign done1           = (state_q == DELIVER) &&  owner_q;
  assign err0            = done0 && err_q;
  assign err1            = done1 && err_q;
  assign res0            = res0_q;
  assign res1            = res1_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench: behavioural signed multiplier model plus directed and randomized requests.
module tb_mult_arbiter;

  localparam int W       = 3;
  localparam int TIMEOUT = 31;

  logic           clk = 1'b0;
  logic           reset;
  logic           req0, req1;
  logic [W-1:0]   a0, b0, a1, b1;
  logic           done0, done1, err0, err1;
  logic [2*W-1:0] res0, res1;
  logic [W-1:0]   m_multiplicando, m_multiplicador;
  logic           m_start, m_fin, busy;
  logic [2*W-1:0] m_resultado;

  int n_chk  = 0;
  int n_fail = 0;

  // Multiplier model knobs
  int stale_n = 0;
  int lat_n   = 3;
  bit hang    = 1'b0;

  mult_arbiter #(.W(W), .TIMEOUT(TIMEOUT), .TW(5)) dut (
    .clk             (clk),
    .reset           (reset),
    .req0            (req0),
    .a0              (a0),
    .b0              (b0),
    .req1            (req1),
    .a1              (a1),
    .b1              (b1),
    .done0           (done0),
    .res0            (res0),
    .err0            (err0),
    .done1           (done1),
    .res1            (res1),
    .err1            (err1),
    .m_multiplicando (m_multiplicando),
    .m_multiplicador (m_multiplicador),
    .m_start         (m_start),
    .m_resultado     (m_resultado),
    .m_fin           (m_fin),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] prod(input logic [W-1:0] a, input logic [W-1:0] b);
    int x, y;
    x = $signed(a);
    y = $signed(b);
    return (2*W)'(x * y);
  endfunction

  // Sequential multiplier: Fin stays high for stale_n cycles after start, then
  // rises with the product stale_n+lat_n cycles after start (never, if hang).
  logic           mm_busy;
  int             mm_cnt;
  logic [2*W-1:0] mm_prod;
  always @(posedge clk) begin
    if (reset) begin
      mm_busy     <= 1'b0;
      mm_cnt      <= 0;
      mm_prod     <= '0;
      m_fin       <= 1'b0;
      m_resultado <= '0;
    end else if (m_start) begin
      mm_busy <= 1'b1;
      mm_cnt  <= 1;
      mm_prod <= prod(m_multiplicando, m_multiplicador);
      m_fin   <= (stale_n > 0);
    end else if (mm_busy) begin
      mm_cnt <= mm_cnt + 1;
      if (!hang && mm_cnt >= stale_n + lat_n) begin
        m_fin       <= 1'b1;
        m_resultado <= mm_prod;
        mm_busy     <= 1'b0;
      end else begin
        m_fin <= (mm_cnt < stale_n);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs until a done pulse; port=-1 if the bound expires, 2 if both dones fire.
  task automatic wait_done(input int limit, input bit scramble,
                           output int port, output logic [2*W-1:0] r, output logic e,
                           output int lat, output int ns,
                           output logic [W-1:0] mc, output logic [W-1:0] mp);
    int t  = 0;
    int st = 0;
    port = -1; r = '0; e = 1'b0; lat = -1; ns = 0; mc = '0; mp = '0;
    while (t < limit && port < 0) begin
      @(negedge clk);
      t++;
      if (m_start) begin
        ns++;
        st = t;
        mc = m_multiplicando;
        mp = m_multiplicador;
        if (scramble) begin
          a0 = 3'($urandom); b0 = 3'($urandom);
          a1 = 3'($urandom); b1 = 3'($urandom);
        end
      end
      if (done0 && done1)  port = 2;
      else if (done0) begin port = 0; r = res0; e = err0; end
      else if (done1) begin port = 1; r = res1; e = err1; end
    end
    if (port >= 0) lat = t - st;
  endtask

  initial begin
    int             port, lat, ns, p, last_served, found;
    logic [2*W-1:0] r, exp_r;
    logic           e;
    logic [W-1:0]   mc, mp, ra, rb;
    logic [2*W-1:0] exp_res [2];

    reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_start", m_start, 0);
    chk("rst_done", {done0, done1, err0, err1}, 0);
    chk("rst_res", {res0, res1}, 0);
    chk("rst_ops", {m_multiplicando, m_multiplicador}, 0);
    reset = 1'b0;
    exp_res[0] = '0; exp_res[1] = '0;

    // Single request on port 0
    req0 = 1'b1; a0 = 3'b011; b0 = 3'b010; lat_n = 3;
    wait_done(60, 1'b0, port, r, e, lat, ns, mc, mp);
    req0 = 1'b0;
    chk("single_port", port, 0);
    chk("single_res", r, 6'd6);
    chk("single_err", e, 0);
    chk("single_starts", ns, 1);
    chk("single_ops", {mc, mp}, {3'd3, 3'd2});
    chk("single_lat", lat, lat_n + 2);
    exp_res[0] = 6'd6;
    @(negedge clk);
    chk("single_pulse", {done0, done1}, 0);
    chk("single_hold", res0, 6'd6);

    // Signed operands on port 1
    req1 = 1'b1; a1 = 3'b111; b1 = 3'b011;
    wait_done(60, 1'b0, port, r, e, lat, ns, mc, mp);
    req1 = 1'b0;
    chk("signed_port", port, 1);
    chk("signed_res", r, 6'b111101);
    chk("signed_other", res0, exp_res[0]);
    exp_res[1] = 6'b111101;

    // Random single-port operations; operands are scrambled after launch
    for (int i = 0; i < 8; i++) begin
      p = $urandom_range(0, 1);
      ra = 3'($urandom); rb = 3'($urandom);
      stale_n = $urandom_range(0, 2);
      lat_n   = $urandom_range(1, 5);
      exp_r   = prod(ra, rb);
      if (p == 0) begin req0 = 1'b1; a0 = ra; b0 = rb; end
      else        begin req1 = 1'b1; a1 = ra; b1 = rb; end
      wait_done(80, 1'b1, port, r, e, lat, ns, mc, mp);
      req0 = 1'b0; req1 = 1'b0;
      chk("rand_port", port, p);
      chk("rand_res", r, exp_r);
      chk("rand_err", e, 0);
      chk("rand_lat", lat, stale_n + lat_n + 2);
      exp_res[p] = exp_r;
      chk("rand_other", (p == 0) ? res1 : res0, exp_res[1-p]);
    end
    stale_n = 0; lat_n = 2;

    // Contention from reset: grants alternate starting at port 0
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_res[0] = '0; exp_res[1] = '0;
    last_served = 1;
    a0 = 3'($urandom); b0 = 3'($urandom); a1 = 3'($urandom); b1 = 3'($urandom);
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      p     = 1 - last_served;
      exp_r = (p == 0) ? prod(a0, b0) : prod(a1, b1);
      wait_done(60, 1'b0, port, r, e, lat, ns, mc, mp);
      chk("cont_port", port, p);
      chk("cont_res", r, exp_r);
      chk("cont_starts", ns, 1);
      last_served = p;
      if (p == 0) begin a0 = 3'($urandom); b0 = 3'($urandom); end
      else        begin a1 = 3'($urandom); b1 = 3'($urandom); end
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);

    // Stale Fin from the previous operation must not be captured
    stale_n = 2; lat_n = 2;
    req0 = 1'b1; a0 = 3'b010; b0 = 3'b110;
    wait_done(60, 1'b0, port, r, e, lat, ns, mc, mp);
    req0 = 1'b0;
    chk("stale_res", r, 6'b111100);
    chk("stale_lat", lat, stale_n + lat_n + 2);
    stale_n = 0;

    // Watchdog timeout, then normal service again
    hang = 1'b1;
    req0 = 1'b1; a0 = 3'b001; b0 = 3'b001;
    wait_done(100, 1'b0, port, r, e, lat, ns, mc, mp);
    req0 = 1'b0;
    chk("to_port", port, 0);
    chk("to_err", e, 1);
    chk("to_res", r, 0);
    chk("to_lat", lat, TIMEOUT + 1);
    hang = 1'b0;
    @(negedge clk);
    req0 = 1'b1; a0 = 3'b011; b0 = 3'b011;
    wait_done(60, 1'b0, port, r, e, lat, ns, mc, mp);
    req0 = 1'b0;
    chk("after_to_res", r, 6'd9);
    chk("after_to_err", e, 0);

    // Reset while waiting on the multiplier; held request is re-served
    hang = 1'b1;
    req0 = 1'b1; a0 = 3'b101; b0 = 3'b010;
    found = 0;
    for (int t = 0; t < 20 && found == 0; t++) begin
      @(negedge clk);
      if (m_start) found = 1;
    end
    chk("mid_start_seen", found, 1);
    repeat (2) @(negedge clk);
    chk("mid_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", {done0, done1, err0, err1, m_start}, 0);
    chk("mid_rst_regs", {res0, res1, m_multiplicando, m_multiplicador}, 0);
    reset = 1'b0; hang = 1'b0; lat_n = 2;
    wait_done(60, 1'b0, port, r, e, lat, ns, mc, mp);
    req0 = 1'b0;
    chk("mid_port", port, 0);
    chk("mid_starts", ns, 1);
    chk("mid_res", r, prod(3'b101, 3'b010));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
- Shares one sequential 3x3 signed multiplier between two requesters (port 0, port 1).
- Latches the winning requester's operands and drives the multiplier's start pulse.
- Waits for the multiplier's Fin, captures resultado and returns it to the owning requester with a one-cycle done pulse.
- Round-robin arbitration; a watchdog flags a multiplier that never finishes.

Parameters:
- W, 3: operand width; the product is 2*W bits.
- TIMEOUT, 31: maximum cycles spent in ARM+WAIT before the operation is aborted.
- TW, 5: watchdog counter width; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- req0  in  1  requester 0 request; level, held until done0
- a0  in  W  requester 0 multiplicand
- b0  in  W  requester 0 multiplier
- req1  in  1  requester 1 request; level, held until done1
- a1  in  W  requester 1 multiplicand
- b1  in  W  requester 1 multiplier
- done0  out  1  one-cycle pulse; res0/err0 valid
- res0  out  2W  requester 0 product, held until the next done0
- err0  out  1  valid with done0; 1 means timeout, and res0 is then 0
- done1, res1, err1  out  1/2W/1  the same for requester 1
- m_multiplicando  out  W  to the multiplier
- m_multiplicador  out  W  to the multiplier
- m_start  out  1  to the multiplier; one-cycle pulse
- m_resultado  in  2W  from the multiplier
- m_fin  in  1  from the multiplier; level, high when the result is valid
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (synchronous, dominates everything):
  - State goes to IDLE.
  - All outputs go to 0: m_* operands, res0, res1, done*, err*, m_start, busy.
  - The round-robin pointer last goes to 1, so port 0 wins the first tie.
  - The watchdog counter clears.
  - Reset mid-operation abandons the operation silently: no done pulse is issued. The requester keeps req high and is re-served after reset.
- Only this block drives the multiplier.
- States: IDLE, LAUNCH, ARM, WAIT, DELIVER.
- IDLE:
  - If neither request is high, stay in IDLE.
  - If exactly one request is high, grant it.
  - If both are high, grant the port that is not last.
  - On a grant: latch a/b into m_multiplicando/m_multiplicador, record the owner, set last to the owner, and go to LAUNCH.
- LAUNCH:
  - m_start=1 for exactly this cycle; the operands are already stable.
  - Next state is ARM; clear the watchdog.
- ARM:
  - Waits for m_fin==0, because Fin may still be high from the previous operation.
  - When m_fin is 0, go to WAIT.
- WAIT:
  - Waits for m_fin==1.
  - On that cycle, capture m_resultado into res[owner] and go to DELIVER.
- Watchdog:
  - Counts every cycle spent in ARM and WAIT.
  - When it reaches TIMEOUT, go to DELIVER with the error flag set and res[owner]=0.
- DELIVER:
  - done[owner]=1 for one cycle and err[owner]=error flag; then return to IDLE.
  - The requester drops req on the cycle after done. If req is still high in IDLE it is treated as a new request.
- Operands stay constant on m_multiplicando/m_multiplicador from the LAUNCH cycle through DELIVER.
- Changes to a/b during service are ignored.
- Minimum latency from grant to done = 1 (LAUNCH) + 1 (ARM) + multiplier latency + 1 (DELIVER).
- Fairness: with both requests held continuously, grants strictly alternate 0,1,0,1.
- A request that drops before it is granted is never served. Dropping req after grant does not cancel the operation; done still pulses.
- res of the non-owner port is never modified.

Decomposition:
- Shared package mult_pkg:
  - state encoding constants (IDLE=0, LAUNCH=1, ARM=2, WAIT=3, DELIVER=4, 3 bits);
  - default W=3.
- One natural sub-module, rr_arbiter2: the two-input round-robin grant logic plus the last pointer. It is combinational grant with a registered pointer updated on an enable.
- The FSM, operand/result registers and watchdog stay in mult_arbiter.

Test Plan:
- Single request:
  - Stimulus: req0=1, a0=3'b011, b0=3'b010, real multiplier attached.
  - Response: one m_start pulse with operands 3/2; then done0 pulse with res0=6'd6 and err0=0; done1 never asserts.
- Signed operands:
  - Stimulus: req1=1, a1=3'b111 (-1), b1=3'b011 (3).
  - Response: res1=6'b111101 (-3); res0 unchanged.
- Contention:
  - Stimulus: req0 and req1 both raised in the same cycle after reset and held.
  - Response: port 0 served first, then port 1, then port 0 again; m_start pulses never overlap an operation in progress.
- Stale Fin:
  - Stimulus: multiplier model holds m_fin=1 for 2 cycles after m_start.
  - Response: the FSM stays in ARM and does not capture early; the correct product is delivered after Fin falls and rises again.
- Timeout:
  - Stimulus: multiplier model never raises m_fin.
  - Response: exactly TIMEOUT cycles after LAUNCH+1, done0=1, err0=1, res0=0; the arbiter returns to IDLE and serves a subsequent request normally.
- Reset mid-operation:
  - Stimulus: assert reset in WAIT.
  - Response: the next cycle has all outputs 0, busy=0 and no done pulse; a held req0 is re-served with a fresh m_start.
